// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, FSM states, WB control fields.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int unsigned WB_REGWRITE    = 0;
  localparam int unsigned WB_MEMTOREG_LO = 1;
  localparam int unsigned WB_MEMTOREG_HI = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } mem_state_e;

  // Bytes are always aligned; halves need an even address; words (and size 11) need addr[1:0]==0.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: is_aligned = 1'b1;
      SZ_HALF: is_aligned = ~lane[0];
      default: is_aligned = (lane == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load formatter: picks the addressed byte/half lane and sign- or zero-extends it.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_addr)
      2'b00:   w_byte = i_rdata[7:0];
      2'b01:   w_byte = i_rdata[15:8];
      2'b10:   w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
  end

  always_comb begin
    o_data = i_rdata;
    case (i_size)
      SZ_BYTE: o_data = i_unsigned ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_HALF: o_data = i_unsigned ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: req/ack data-memory access with stall, load formatting,
// misalignment and timeout detection, and WB control pass-through.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_VALID,
  input  logic        MEM_MEMREAD,
  input  logic        MEM_MEMWRITE,
  input  logic [1:0]  MEM_SIZE,
  input  logic        MEM_UNSIGNED,
  input  logic [31:0] MEM_ALU_RESULT,
  input  logic [31:0] MEM_WR_DATA,
  input  logic [2:0]  WB_CTRL,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [3:0]  DMEM_BE,
  output logic [31:0] DMEM_ADDR,
  output logic [31:0] DMEM_WDATA,
  input  logic [31:0] DMEM_RDATA,
  input  logic        DMEM_ACK,
  output logic        STALL,
  output logic [31:0] MEM_RD_DATA,
  output logic [2:0]  WB_CTRL_OUT,
  output logic        MISALIGN,
  output logic        BUS_ERR
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  mem_state_e       r_state, w_next;
  logic             w_mem_op, w_aligned, w_issue, w_timeout;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata, w_ld_data;
  logic [31:0]      r_addr, r_wdata, r_rdata;
  logic [3:0]       r_be;
  logic [1:0]       r_size;
  logic [2:0]       r_wb;
  logic             r_we, r_uns, r_err;
  logic [CNT_W-1:0] r_cnt;

  assign w_mem_op  = MEM_VALID & (MEM_MEMREAD | MEM_MEMWRITE);
  assign w_aligned = is_aligned(MEM_SIZE, MEM_ALU_RESULT[1:0]);
  assign w_issue   = (r_state == ST_IDLE) & w_mem_op & w_aligned;
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  // Store data replicated into every lane; byte enables select the addressed lane(s).
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = MEM_WR_DATA;
    case (MEM_SIZE)
      SZ_BYTE: begin
        w_be    = 4'b0001 << MEM_ALU_RESULT[1:0];
        w_wdata = {4{MEM_WR_DATA[7:0]}};
      end
      SZ_HALF: begin
        w_be    = MEM_ALU_RESULT[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{MEM_WR_DATA[15:0]}};
      end
      default: ;
    endcase
  end

  mem_load_align u_load_align (
    .i_rdata    (r_rdata),
    .i_addr     (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .o_data     (w_ld_data)
  );

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    DMEM_REQ    = 1'b0;
    DMEM_WE     = 1'b0;
    DMEM_BE     = 4'b0000;
    DMEM_ADDR   = 32'h0;
    DMEM_WDATA  = 32'h0;
    STALL       = 1'b0;
    MEM_RD_DATA = 32'h0;
    WB_CTRL_OUT = WB_CTRL;
    MISALIGN    = 1'b0;
    BUS_ERR     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_mem_op && !w_aligned) begin
          MISALIGN                 = 1'b1;
          WB_CTRL_OUT[WB_REGWRITE] = 1'b0;
        end
        if (w_issue) begin
          w_next                   = ST_REQ;
          STALL                    = 1'b1;
          WB_CTRL_OUT[WB_REGWRITE] = 1'b0;
        end
      end
      ST_REQ: begin
        DMEM_REQ                 = 1'b1;
        DMEM_WE                  = r_we;
        DMEM_BE                  = r_be;
        DMEM_ADDR                = {r_addr[31:2], 2'b00};
        DMEM_WDATA               = r_wdata;
        STALL                    = 1'b1;
        WB_CTRL_OUT              = r_wb;
        WB_CTRL_OUT[WB_REGWRITE] = 1'b0;
        if (DMEM_ACK || w_timeout) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_next      = ST_IDLE;
        MEM_RD_DATA = w_ld_data;
        WB_CTRL_OUT = r_wb;
        if (r_err) begin
          WB_CTRL_OUT[WB_REGWRITE] = 1'b0;
          BUS_ERR                  = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Access latches; read data stays zero for stores and timed-out loads.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_addr  <= 32'h0;
      r_we    <= 1'b0;
      r_be    <= 4'b0000;
      r_wdata <= 32'h0;
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_wb    <= 3'b000;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            r_addr  <= MEM_ALU_RESULT;
            r_we    <= MEM_MEMWRITE;
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_size  <= MEM_SIZE;
            r_uns   <= MEM_UNSIGNED;
            r_wb    <= WB_CTRL;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
          end
        end
        ST_REQ: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (DMEM_ACK) begin
            if (!r_we) r_rdata <= DMEM_RDATA;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= 32'h0;
          end
        end
        ST_DONE: r_cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: stimulus pushes per-cycle expected
// outputs, a monitor pops and compares them on the falling edge.
module tb_mem_access_stage;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        MEM_VALID, MEM_MEMREAD, MEM_MEMWRITE, MEM_UNSIGNED;
  logic [1:0]  MEM_SIZE;
  logic [31:0] MEM_ALU_RESULT, MEM_WR_DATA;
  logic [2:0]  WB_CTRL;
  logic        DMEM_REQ, DMEM_WE, DMEM_ACK;
  logic [3:0]  DMEM_BE;
  logic [31:0] DMEM_ADDR, DMEM_WDATA, DMEM_RDATA;
  logic        STALL, MISALIGN, BUS_ERR;
  logic [31:0] MEM_RD_DATA;
  logic [2:0]  WB_CTRL_OUT;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rd;
    logic [2:0]  wb;
    logic        mis;
    logic        berr;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_err    = 0;

  mem_access_stage #(.TIMEOUT(4)) dut (
    .CLK(CLK), .RESET(RESET), .MEM_VALID(MEM_VALID), .MEM_MEMREAD(MEM_MEMREAD),
    .MEM_MEMWRITE(MEM_MEMWRITE), .MEM_SIZE(MEM_SIZE), .MEM_UNSIGNED(MEM_UNSIGNED),
    .MEM_ALU_RESULT(MEM_ALU_RESULT), .MEM_WR_DATA(MEM_WR_DATA), .WB_CTRL(WB_CTRL),
    .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_BE(DMEM_BE), .DMEM_ADDR(DMEM_ADDR),
    .DMEM_WDATA(DMEM_WDATA), .DMEM_RDATA(DMEM_RDATA), .DMEM_ACK(DMEM_ACK),
    .STALL(STALL), .MEM_RD_DATA(MEM_RD_DATA), .WB_CTRL_OUT(WB_CTRL_OUT),
    .MISALIGN(MISALIGN), .BUS_ERR(BUS_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_in(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] wb);
    MEM_VALID = v; MEM_MEMREAD = rd; MEM_MEMWRITE = wr; MEM_SIZE = sz;
    MEM_UNSIGNED = uns; MEM_ALU_RESULT = addr; MEM_WR_DATA = wd; WB_CTRL = wb;
  endtask

  task automatic set_ack(input logic a, input logic [31:0] d);
    DMEM_ACK = a; DMEM_RDATA = d;
  endtask

  task automatic ex(input string nm, input logic req, input logic we, input logic [3:0] be,
                    input logic [31:0] addr, input logic [31:0] wdata, input logic stall,
                    input logic [31:0] rd, input logic [2:0] wb, input logic mis,
                    input logic berr);
    exp_q.push_back('{req, we, be, addr, wdata, stall, rd, wb, mis, berr});
    name_q.push_back(nm);
  endtask

  task automatic ex_idle(input string nm, input logic [2:0] wb);
    ex(nm, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, wb, 1'b0, 1'b0);
  endtask

  // Aligned access: issue cycle, n_wait REQ cycles without ACK, ACK cycle, DONE cycle.
  task automatic mem_op(input string nm, input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] wb, input int n_wait, input logic [31:0] rdata,
                        input logic [3:0] e_be, input logic [31:0] e_addr,
                        input logic [31:0] e_wdata, input logic [31:0] e_rd,
                        input logic [2:0] e_wb_done);
    logic [2:0] wb_bub;
    wb_bub = {wb[2:1], 1'b0};
    tick(); set_in(1'b1, rd, wr, sz, uns, addr, wd, wb); set_ack(1'b0, 32'h0);
    ex({nm, "_issue"}, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0, wb_bub, 1'b0, 1'b0);
    for (int i = 0; i < n_wait; i++) begin
      tick();
      ex({nm, "_wait"}, 1'b1, wr, e_be, e_addr, e_wdata, 1'b1, 32'h0, wb_bub, 1'b0, 1'b0);
    end
    tick(); set_ack(1'b1, rdata);
    ex({nm, "_ack"}, 1'b1, wr, e_be, e_addr, e_wdata, 1'b1, 32'h0, wb_bub, 1'b0, 1'b0);
    tick(); set_ack(1'b0, 32'h0);
    ex({nm, "_done"}, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, e_rd, e_wb_done, 1'b0, 1'b0);
  endtask

  // Monitor: compares every presented cycle against the scoreboard head.
  initial begin
    obs_t  e, a;
    string nm;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = {DMEM_REQ, DMEM_WE, DMEM_BE, DMEM_ADDR, DMEM_WDATA, STALL, MEM_RD_DATA,
              WB_CTRL_OUT, MISALIGN, BUS_ERR};
        n_checks++;
        if (a !== e) begin
          n_err++;
          $display("FAIL %s: got req=%b we=%b be=%h addr=%h wdata=%h stall=%b rd=%h wb=%b mis=%b berr=%b | want req=%b we=%b be=%h addr=%h wdata=%h stall=%b rd=%h wb=%b mis=%b berr=%b",
                   nm, a.req, a.we, a.be, a.addr, a.wdata, a.stall, a.rd, a.wb, a.mis, a.berr,
                   e.req, e.we, e.be, e.addr, e.wdata, e.stall, e.rd, e.wb, e.mis, e.berr);
        end
      end
    end
  end

  initial begin
    RESET = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 3'b000);
    set_ack(1'b0, 32'h0);
    tick();
    tick();
    ex_idle("reset", 3'b000);
    tick(); RESET = 1'b0;
    set_in(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 3'b001);
    ex_idle("alu_pass", 3'b001);

    mem_op("lw", 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 3'b011, 1, 32'hDEADBEEF,
           4'hF, 32'h10, 32'h0, 32'hDEADBEEF, 3'b011);
    tick(); set_in(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 3'b000);
    ex_idle("bubble1", 3'b000);

    mem_op("lb", 1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 3'b011, 0, 32'h80FF0000,
           4'b1000, 32'h10, 32'h0, 32'hFFFFFF80, 3'b011);
    mem_op("lbu", 1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 3'b011, 0, 32'h80FF0000,
           4'b1000, 32'h10, 32'h0, 32'h00000080, 3'b011);
    mem_op("lh", 1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 3'b011, 0, 32'h80015555,
           4'b1100, 32'h10, 32'h0, 32'hFFFF8001, 3'b011);
    mem_op("sh", 1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h1234ABCD, 3'b000, 0, 32'hFFFFFFFF,
           4'b1100, 32'h10, 32'hABCDABCD, 32'h0, 3'b000);
    mem_op("sb", 1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h000000A5, 3'b000, 2, 32'h0,
           4'b0010, 32'h20, 32'hA5A5A5A5, 32'h0, 3'b000);

    tick(); set_in(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h11, 32'h0, 3'b011);
    ex("lw_misalign", 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 3'b010, 1'b1, 1'b0);
    tick(); set_in(1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 32'h13, 32'h0, 3'b001);
    ex("sh_misalign", 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 3'b000, 1'b1, 1'b0);
    tick(); set_in(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 3'b000);
    ex_idle("bubble2", 3'b000);

    // Timeout: four REQ cycles, then DONE with error; ACK in DONE is ignored.
    tick(); set_in(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 3'b011);
    ex("to_issue", 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0, 3'b010, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      ex("to_req", 1'b1, 1'b0, 4'hF, 32'h20, 32'h0, 1'b1, 32'h0, 3'b010, 1'b0, 1'b0);
    end
    tick(); set_ack(1'b1, 32'hCAFEF00D);
    ex("to_done", 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0, 3'b010, 1'b0, 1'b1);
    tick(); set_in(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 3'b000);
    ex_idle("to_idle", 3'b000);
    tick(); set_ack(1'b0, 32'h0);
    ex_idle("to_idle2", 3'b000);

    // Reset while in REQ; a late ACK must not produce a DONE.
    tick(); set_in(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 3'b011);
    ex("rst_issue", 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h0, 3'b010, 1'b0, 1'b0);
    tick();
    ex("rst_req1", 1'b1, 1'b0, 4'hF, 32'h30, 32'h0, 1'b1, 32'h0, 3'b010, 1'b0, 1'b0);
    tick(); RESET = 1'b1;
    ex("rst_req2", 1'b1, 1'b0, 4'hF, 32'h30, 32'h0, 1'b1, 32'h0, 3'b010, 1'b0, 1'b0);
    tick(); RESET = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 3'b000);
    set_ack(1'b1, 32'h12345678);
    ex_idle("rst_late_ack", 3'b000);
    tick(); set_ack(1'b0, 32'h0);
    ex_idle("rst_after", 3'b000);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: %0d expected cycles left unchecked, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
